// File: rtl/f8_pkg.sv
// Shared types and constants for the f8 instruction prefetch stage.
package f8_pkg;

    localparam int ADDR_W      = 16;
    localparam int FETCH_BYTES = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    // Three consecutive bytes; element 0 is the lowest address.
    typedef logic [FETCH_BYTES-1:0][7:0] fetch_window_t;

    localparam addr_t RESET_VECTOR_DEFAULT = 16'h4000;

    // The decoder may ask for more bytes than are presented; it only gets what is there.
    function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [1:0] avail);
        return (req > avail) ? avail : req;
    endfunction

endpackage

// File: rtl/f8_ifetch_if.sv
// Bundle between the prefetch stage, the instruction ROM and the decoder.
//
// Protocol: a ROM read is issued whenever the fetch unit decides to (there is no
// ready). The ROM returns the 3-byte window for the address presented in the
// previous cycle; iread_valid qualifies that window in the response cycle and a
// low iread_valid means the response is lost and must be re-requested. On the
// decoder side, out_count bytes are valid at out_bytes; the decoder consumes
// pop_len of them this cycle (anything above out_count is ignored), and a
// redirect discards everything and restarts at redirect_addr.
interface f8_ifetch_if;
    import f8_pkg::*;

    addr_t         iread_addr;
    fetch_window_t iread_data;
    logic          iread_valid;

    logic          redirect;
    addr_t         redirect_addr;
    logic [1:0]    pop_len;

    fetch_window_t out_bytes;
    logic [1:0]    out_count;
    addr_t         out_pc;

    // Internal fetch state made visible for checkers.
    logic          dbg_inflight;
    logic          dbg_drop;
    logic [7:0]    dbg_fill;

    modport master (
        output iread_addr, out_bytes, out_count, out_pc,
        output dbg_inflight, dbg_drop, dbg_fill,
        input  iread_data, iread_valid, redirect, redirect_addr, pop_len
    );

    modport slave (
        input  iread_addr, out_bytes, out_count, out_pc,
        input  dbg_inflight, dbg_drop, dbg_fill,
        output iread_data, iread_valid, redirect, redirect_addr, pop_len
    );

endinterface

// File: rtl/f8_byte_queue.sv
// Circular byte queue: pushes a whole 3-byte window, pops 0-3 bytes, flushes at once.
module f8_byte_queue
    import f8_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_window_t    push_data_i,
    input  logic [1:0]       pop_i,
    output fetch_window_t    head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer/count update; a flush empties the queue by catching rd up to wr.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(FETCH_BYTES);
            end
            count_d = count_q - CNT_W'(pop_i) + (push_i ? CNT_W'(FETCH_BYTES) : '0);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: the three bytes of a window land at consecutive slots, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                mem_q[wr_ptr_q + PTR_W'(k)] <= push_data_i[k];
            end
        end
    end

    // Head window; slots beyond the fill level read as zero.
    always_comb begin
        head_o = '0;
        for (int k = 0; k < FETCH_BYTES; k++) begin
            if (count_q > CNT_W'(k)) begin
                head_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/f8_ifetch.sv
// Instruction prefetch: keeps the byte queue topped up from the ROM and presents
// the next up-to-3 instruction bytes with their PC to the decoder.
module f8_ifetch
    import f8_pkg::*;
#(
    parameter int    DEPTH        = 8,
    parameter addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    f8_ifetch_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    addr_t fetch_addr_q, fetch_addr_d;
    addr_t req_addr_q,   req_addr_d;
    addr_t out_pc_q,     out_pc_d;
    logic  inflight_q,   inflight_d;
    logic  drop_q,       drop_d;

    logic [CNT_W-1:0] fill;
    logic [1:0]       out_count;
    logic [1:0]       pop_eff;
    logic [SUM_W-1:0] reserved;
    logic             push;
    logic             lost;
    logic             issue;

    assign out_count = (fill >= CNT_W'(FETCH_BYTES)) ? 2'd3 : fill[1:0];
    assign pop_eff   = bus.redirect ? 2'd0 : clamp_pop(bus.pop_len, out_count);

    assign push = inflight_q && !drop_q && !bus.redirect &&  bus.iread_valid;
    assign lost = inflight_q && !drop_q && !bus.redirect && !bus.iread_valid;

    // Space already spoken for: what stays after this cycle's pop plus a window
    // still in flight. Bytes popped this cycle count as free, which is what lets
    // a decoder eating 3 bytes every cycle run without bubbles at DEPTH = 8.
    assign reserved = SUM_W'(fill) - SUM_W'(pop_eff) + (inflight_q ? SUM_W'(FETCH_BYTES) : '0);
    assign issue    = !bus.redirect && !lost && (reserved <= SUM_W'(DEPTH - FETCH_BYTES));

    // Next fetch/PC state: redirect wins, then rewind on a lost response, then issue.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        out_pc_d     = out_pc_q + addr_t'(pop_eff);
        inflight_d   = issue;
        drop_d       = 1'b0;
        if (bus.redirect) begin
            fetch_addr_d = bus.redirect_addr;
            out_pc_d     = bus.redirect_addr;
            drop_d       = inflight_q;
        end else if (lost) begin
            fetch_addr_d = req_addr_q;
        end else if (issue) begin
            req_addr_d   = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + addr_t'(FETCH_BYTES);
        end
    end

    // Fetch state registers; an in-flight response is forgotten on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= RESET_VECTOR;
            req_addr_q   <= RESET_VECTOR;
            out_pc_q     <= RESET_VECTOR;
            inflight_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            out_pc_q     <= out_pc_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
        end
    end

    f8_byte_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (bus.redirect),
        .push_i      (push),
        .push_data_i (bus.iread_data),
        .pop_i       (pop_eff),
        .head_o      (bus.out_bytes),
        .count_o     (fill)
    );

    assign bus.iread_addr   = fetch_addr_q;
    assign bus.out_count    = out_count;
    assign bus.out_pc       = out_pc_q;
    assign bus.dbg_inflight = inflight_q;
    assign bus.dbg_drop     = drop_q;
    assign bus.dbg_fill     = 8'(fill);

endmodule

// File: tb/tb_f8_ifetch.sv
// Bench for f8_ifetch: ROM model, byte-stream reference model, directed and random stimulus.
module tb_f8_ifetch;
    import f8_pkg::*;

    localparam int    DEPTH = 8;
    localparam addr_t RV    = 16'h4000;

    logic clk;
    logic reset;
    bit   rom_mode;
    addr_t rom_addr_lat;

    int total;
    int bad;

    f8_ifetch_if bus ();

    f8_ifetch #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- ROM image ----------------
    function automatic logic [7:0] rom_byte(input addr_t a, input bit mode);
        return mode ? (a[7:0] ^ a[15:8] ^ 8'h5a) : a[7:0];
    endfunction

    function automatic logic [23:0] rom_window(input addr_t a, input bit mode);
        return {rom_byte(a + 16'd2, mode), rom_byte(a + 16'd1, mode), rom_byte(a, mode)};
    endfunction

    // The ROM answers the address it saw in the previous cycle.
    always @(posedge clk) rom_addr_lat <= bus.iread_addr;

    assign bus.iread_data = bus.iread_valid ? rom_window(rom_addr_lat, rom_mode) : 24'ha5c3e1;

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    addr_t m_pc, m_fetch, m_req;
    bit    m_inflight, m_drop;
    int    m_n, m_oc, m_pe;
    bit    m_got, m_lost, m_iss;

    function automatic int m_out_count();
        return (exp_q.size() > 3) ? 3 : exp_q.size();
    endfunction

    // One clock of the fetch rules, applied to a plain byte queue.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_pc       = RV;
            m_fetch    = RV;
            m_req      = RV;
            m_inflight = 1'b0;
            m_drop     = 1'b0;
        end else if (bus.redirect) begin
            exp_q.delete();
            m_pc       = bus.redirect_addr;
            m_fetch    = bus.redirect_addr;
            m_drop     = m_inflight;
            m_inflight = 1'b0;
        end else begin
            m_n    = exp_q.size();
            m_oc   = (m_n > 3) ? 3 : m_n;
            m_pe   = (int'(bus.pop_len) > m_oc) ? m_oc : int'(bus.pop_len);
            m_got  = m_inflight && !m_drop && bus.iread_valid;
            m_lost = m_inflight && !m_drop && !bus.iread_valid;
            // Issue only if every byte already promised plus this window still fits.
            m_iss  = !m_lost && ((m_n - m_pe) + (m_inflight ? 3 : 0) + 3 <= DEPTH);
            repeat (m_pe) void'(exp_q.pop_front());
            m_pc = m_pc + 16'(m_pe);
            if (m_got) begin
                for (int k = 0; k < 3; k++) exp_q.push_back(rom_byte(m_req + 16'(k), rom_mode));
            end
            if (m_lost) begin
                m_fetch = m_req;
            end else if (m_iss) begin
                m_req   = m_fetch;
                m_fetch = m_fetch + 16'd3;
            end
            m_inflight = m_iss;
            m_drop     = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [23:0] exp_bytes;
    int          c_oc;

    // Every cycle out of reset, the DUT must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            c_oc      = m_out_count();
            exp_bytes = '0;
            for (int k = 0; k < 3; k++) begin
                if (k < c_oc) exp_bytes[8*k +: 8] = exp_q[k];
            end
            chk("iread_addr", 32'(bus.iread_addr), 32'(m_fetch));
            chk("out_pc", 32'(bus.out_pc), 32'(m_pc));
            chk("out_count", 32'(bus.out_count), 32'(c_oc));
            chk("out_bytes", 32'(bus.out_bytes), 32'(exp_bytes));
            chk("fill", 32'(bus.dbg_fill), 32'(exp_q.size()));
            chk("inflight", 32'(bus.dbg_inflight), 32'(m_inflight));
            for (int k = 0; k < 3; k++) begin
                if (k < c_oc) chk("rom_order", 32'(bus.out_bytes[k]), 32'(rom_byte(bus.out_pc + 16'(k), rom_mode)));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic rd, input addr_t ra, input logic [1:0] pl, input logic vld);
        bus.redirect      = rd;
        bus.redirect_addr = ra;
        bus.pop_len       = pl;
        bus.iread_valid   = vld;
        @(posedge clk);
        #1;
    endtask

    addr_t lit_pc;
    int    pat [4] = '{1, 2, 3, 1};
    int    pe;
    bit    found;

    initial begin
        total = 0;
        bad   = 0;
        rom_mode = 1'b0;
        reset = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.pop_len       = '0;
        bus.iread_valid   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_bytes", 32'(bus.out_bytes), 32'd0);
        chk("rst_pc", 32'(bus.out_pc), 32'h4000);
        chk("rst_iaddr", 32'(bus.iread_addr), 32'h4000);
        reset = 1'b0;

        // Fill from reset: first window visible after two clocks, then stall at 6 bytes.
        drive(1'b0, '0, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b1);
        chk("fill_count", 32'(bus.out_count), 32'd3);
        chk("fill_bytes", 32'(bus.out_bytes), 32'h020100);
        chk("fill_pc", 32'(bus.out_pc), 32'h4000);
        repeat (4) drive(1'b0, '0, 2'd0, 1'b1);
        chk("full_iaddr", 32'(bus.iread_addr), 32'h4006);
        chk("full_fill", 32'(bus.dbg_fill), 32'd6);

        // Steady 3-byte pops.
        lit_pc = RV;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 2'd3, 1'b1);
            lit_pc = lit_pc + 16'd3;
            chk("steady_count", 32'(bus.out_count), 32'd3);
            chk("steady_pc", 32'(bus.out_pc), 32'(lit_pc));
        end

        // Mixed pop sizes across the queue wrap.
        for (int i = 0; i < 24; i++) begin
            pe = (pat[i % 4] > m_out_count()) ? m_out_count() : pat[i % 4];
            drive(1'b0, '0, 2'(pe), 1'b1);
            lit_pc = lit_pc + 16'(pe);
            chk("mixed_pc", 32'(bus.out_pc), 32'(lit_pc));
        end

        // Steer to 5 bytes queued with a window in flight, then redirect.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (exp_q.size() == 5 && m_inflight) found = 1'b1;
            else drive(1'b0, '0, (m_out_count() > 0) ? 2'd1 : 2'd0, 1'b1);
        end
        chk("redirect_setup", 32'(found), 32'd1);
        drive(1'b1, 16'h4100, 2'd2, 1'b1);
        chk("redir_count0", 32'(bus.out_count), 32'd0);
        chk("redir_pc0", 32'(bus.out_pc), 32'h4100);
        drive(1'b0, '0, 2'd0, 1'b1);
        chk("redir_count1", 32'(bus.out_count), 32'd0);
        chk("redir_iaddr1", 32'(bus.iread_addr), 32'h4103);
        drive(1'b0, '0, 2'd0, 1'b1);
        chk("redir_count2", 32'(bus.out_count), 32'd3);
        chk("redir_bytes2", 32'(bus.out_bytes), 32'h020100);
        chk("redir_pc2", 32'(bus.out_pc), 32'h4100);

        // Lose the response for the window at 0x4003.
        drive(1'b1, 16'h4000, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b0);
        chk("lost_iaddr", 32'(bus.iread_addr), 32'h4003);
        chk("lost_count", 32'(bus.out_count), 32'd3);
        drive(1'b0, '0, 2'd3, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b1);
        chk("lost_bytes", 32'(bus.out_bytes), 32'h050403);
        chk("lost_pc", 32'(bus.out_pc), 32'h4003);

        // Fill to 6 and hit reset between clock edges.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (exp_q.size() == 6) found = 1'b1;
            else drive(1'b0, '0, 2'd0, 1'b1);
        end
        chk("arst_setup", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(bus.out_count), 32'd0);
        chk("arst_bytes", 32'(bus.out_bytes), 32'd0);
        chk("arst_pc", 32'(bus.out_pc), 32'h4000);
        chk("arst_iaddr", 32'(bus.iread_addr), 32'h4000);
        rom_mode = 1'b1;
        drive(1'b0, '0, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b1);
        reset = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0, 1'b1);
        chk("refill_count", 32'(bus.out_count), 32'd3);
        chk("refill_bytes", 32'(bus.out_bytes), 32'h181b1a);
        chk("refill_pc", 32'(bus.out_pc), 32'h4000);

        // Random traffic: redirects (some near the top of memory), lost responses, legal pops.
        for (int i = 0; i < 400; i++) begin
            logic  rd;
            addr_t ra;
            logic  vld;
            logic [1:0] pl;
            rd  = ($urandom_range(0, 15) == 0);
            ra  = ($urandom_range(0, 3) == 0) ? 16'hfffd : 16'($urandom());
            vld = ($urandom_range(0, 7) != 0);
            pl  = 2'($urandom_range(0, m_out_count()));
            drive(rd, ra, pl, vld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
